// File: rtl/aer_pkg.sv
//------------------------------------------------------------------------------
// aer_pkg : shared types and constants for AER serializer blocks
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      RELEASE = 2'd2
   } aer_ser_state_t;

   localparam int AER_SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/aer_sync2.sv
//------------------------------------------------------------------------------
// aer_sync2 : multi-flop level synchronizer for asynchronous AER handshake lines
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aer_sync2
   import aer_pkg::*;
#(
   parameter int STAGES = AER_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/aer_bit_serializer.sv
//------------------------------------------------------------------------------
// aer_bit_serializer : sends an AER address MSB first over One/Zero bit cells.
// Define AER_PARITY_EN to append an even-parity bit. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aer_bit_serializer
   import aer_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ev_valid,
   input  logic [ADDR_W-1:0] ev_addr,
   output logic              ev_ready,
   output logic              one,
   output logic              zero,
   input  logic              dt,
   output logic              senack,
   output logic              done,
   output logic              err
);

`ifdef AER_PARITY_EN
   localparam int c_NBITS = ADDR_W + 1;
`else
   localparam int c_NBITS = ADDR_W;
`endif
   localparam int                 c_CNT_W    = $clog2(c_NBITS + 1);
   localparam int                 c_PH_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_NBITS);
   localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(TIMEOUT_CYC - 1);

   aer_ser_state_t     r_state, w_state_nx;
   logic [c_NBITS-1:0] r_shift, w_shift_nx;
   logic [c_CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [c_PH_W-1:0]  r_phase, w_phase_nx;
   logic               r_one, w_one_nx;
   logic               r_zero, w_zero_nx;
   logic               r_senack, w_senack_nx;
   logic               r_done, w_done_nx;
   logic               r_err, w_err_nx;
   logic               w_dt_s;
   logic [c_NBITS-1:0] w_load;
   logic [c_NBITS-1:0] w_shifted;

   aer_sync2 #(
      .STAGES (AER_SYNC_STAGES)
   ) u_dt_sync (
      .clk   (clk),
      .reset (reset),
      .d     (dt),
      .q     (w_dt_s)
   );

`ifdef AER_PARITY_EN
   assign w_load = {ev_addr, ^ev_addr};
`else
   assign w_load = ev_addr;
`endif

   assign w_shifted = {r_shift[c_NBITS-2:0], 1'b0};

   // Blocking ready during the done pulse keeps frames at least one idle cycle apart.
   assign ev_ready = (r_state == IDLE) && !r_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_phase  <= '0;
         r_one    <= 1'b0;
         r_zero   <= 1'b0;
         r_senack <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_shift  <= w_shift_nx;
         r_cnt    <= w_cnt_nx;
         r_phase  <= w_phase_nx;
         r_one    <= w_one_nx;
         r_zero   <= w_zero_nx;
         r_senack <= w_senack_nx;
         r_done   <= w_done_nx;
         r_err    <= w_err_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_shift_nx  = r_shift;
      w_cnt_nx    = r_cnt;
      w_phase_nx  = '0;
      w_one_nx    = r_one;
      w_zero_nx   = r_zero;
      w_senack_nx = r_senack;
      w_done_nx   = 1'b0;
      w_err_nx    = 1'b0;

      case (r_state)
         IDLE: begin
            if (ev_valid && ev_ready) begin
               w_shift_nx = w_load;
               w_cnt_nx   = c_CNT_LOAD;
               w_one_nx   = w_load[c_NBITS-1];
               w_zero_nx  = !w_load[c_NBITS-1];
               w_state_nx = DRIVE;
            end
         end

         DRIVE: begin
            if (w_dt_s) begin
               w_one_nx    = 1'b0;
               w_zero_nx   = 1'b0;
               w_senack_nx = 1'b1;
               w_state_nx  = RELEASE;
            end else if (r_phase == c_PH_LAST) begin
               w_one_nx    = 1'b0;
               w_zero_nx   = 1'b0;
               w_senack_nx = 1'b0;
               w_err_nx    = 1'b1;
               w_state_nx  = IDLE;
            end else begin
               w_phase_nx = r_phase + c_PH_W'(1);
            end
         end

         RELEASE: begin
            if (!w_dt_s) begin
               w_senack_nx = 1'b0;
               w_shift_nx  = w_shifted;
               if (r_cnt != '0) begin
                  w_cnt_nx = r_cnt - c_CNT_W'(1);
               end
               if (r_cnt > c_CNT_W'(1)) begin
                  w_one_nx   = w_shifted[c_NBITS-1];
                  w_zero_nx  = !w_shifted[c_NBITS-1];
                  w_state_nx = DRIVE;
               end else begin
                  w_done_nx  = 1'b1;
                  w_state_nx = IDLE;
               end
            end else if (r_phase == c_PH_LAST) begin
               w_senack_nx = 1'b0;
               w_err_nx    = 1'b1;
               w_state_nx  = IDLE;
            end else begin
               w_phase_nx = r_phase + c_PH_W'(1);
            end
         end

         default: begin
            w_one_nx    = 1'b0;
            w_zero_nx   = 1'b0;
            w_senack_nx = 1'b0;
            w_state_nx  = IDLE;
         end
      endcase
   end

   assign one    = r_one;
   assign zero   = r_zero;
   assign senack = r_senack;
   assign done   = r_done;
   assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_aer_bit_serializer.sv
//------------------------------------------------------------------------------
// tb_aer_bit_serializer : directed bench with a bit-cell handshake model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_aer_bit_serializer;

   localparam int ADDR_W      = 8;
   localparam int TIMEOUT_CYC = 15;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              ev_valid = 1'b0;
   logic [ADDR_W-1:0] ev_addr = '0;
   logic              ev_ready;
   logic              one;
   logic              zero;
   logic              dt = 1'b0;
   logic              senack;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;
   int n_err    = 0;

   aer_bit_serializer #(
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ev_valid (ev_valid),
      .ev_addr  (ev_addr),
      .ev_ready (ev_ready),
      .one      (one),
      .zero     (zero),
      .dt       (dt),
      .senack   (senack),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) n_done++;
      if (err)  n_err++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one event once the serializer is ready; returns after the accept edge.
   task automatic send_event(input logic [ADDR_W-1:0] addr, input logic hold);
      int t;
      t = 0;
      while (!ev_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("ready_wait", 32'(t < 40), 32'd1);
      ev_valid = 1'b1;
      ev_addr  = addr;
      @(negedge clk);
      ev_valid = hold;
   endtask

   // Bit-cell model: ack 4 cycles after a request, release one cycle after senack.
   task automatic cell_frame(input int nbits, output logic [15:0] bits);
      int t;
      bits = '0;
      for (int b = 0; b < nbits; b++) begin
         t = 0;
         while (!(one || zero) && t < 40) begin
            @(negedge clk);
            t++;
         end
         check("req_wait", 32'(t < 40), 32'd1);
         check("one_hot", 32'(one & zero), 32'd0);
         bits = {bits[14:0], one};
         repeat (4) @(negedge clk);
         dt = 1'b1;
         t = 0;
         while (!senack && t < 40) begin
            @(negedge clk);
            t++;
         end
         check("ack_wait", 32'(t < 40), 32'd1);
         check("req_drop", 32'({one, zero}), 32'd0);
         @(negedge clk);
         dt = 1'b0;
         t = 0;
         while (senack && t < 40) begin
            @(negedge clk);
            t++;
         end
         check("rel_wait", 32'(t < 40), 32'd1);
      end
   endtask

   initial begin
      logic [15:0] bits;
      int          d0;
      int          e0;
      int          t;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outs", 32'({ev_ready, one, zero, senack, done, err}), 32'b100000);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 0xA5, one frame, one done, no err
      d0 = n_done;
      e0 = n_err;
      send_event(8'hA5, 1'b0);
      check("a5_first_bit", 32'({ev_ready, one, zero}), 32'b010);
      cell_frame(8, bits);
      check("a5_bits", 32'(bits), 32'h00A5);
      check("a5_done_now", 32'(done), 32'd1);
      repeat (3) @(negedge clk);
      check("a5_done_cnt", 32'(n_done - d0), 32'd1);
      check("a5_err_cnt", 32'(n_err - e0), 32'd0);

      // ev_valid held with 0x3C during a 0x5A frame
      send_event(8'h5A, 1'b1);
      ev_addr = 8'h3C;
      cell_frame(8, bits);
      check("5a_bits", 32'(bits), 32'h005A);
      check("5a_done_noready", 32'({done, ev_ready}), 32'b10);
      @(negedge clk);
      check("3c_ready_back", 32'({ev_ready, one, zero}), 32'b100);
      @(negedge clk);
      check("3c_start", 32'({ev_ready, one, zero}), 32'b001);
      ev_valid = 1'b0;
      cell_frame(8, bits);
      check("3c_bits", 32'(bits), 32'h003C);
      repeat (2) @(negedge clk);

      // DRIVE timeout: dt never rises
      d0 = n_done;
      send_event(8'h80, 1'b0);
      check("to_req_on", 32'(one), 32'd1);
      repeat (14) @(negedge clk);
      check("to_before", 32'({err, one}), 32'b01);
      @(negedge clk);
      check("to_err", 32'({err, one, zero, senack}), 32'b1000);
      @(negedge clk);
      check("to_idle", 32'({err, ev_ready, one, zero, senack}), 32'b01000);
      check("to_no_done", 32'(n_done - d0), 32'd0);

      // RELEASE timeout: dt stuck high
      send_event(8'h80, 1'b0);
      dt = 1'b1;
      t = 0;
      while (!senack && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("st_ack_wait", 32'(t < 40), 32'd1);
      repeat (14) @(negedge clk);
      check("st_before", 32'({err, senack}), 32'b01);
      @(negedge clk);
      check("st_err", 32'({err, senack, one, zero}), 32'b1000);
      dt = 1'b0;
      repeat (4) @(negedge clk);

      // Reset during the fourth bit of 0xFF
      d0 = n_done;
      e0 = n_err;
      send_event(8'hFF, 1'b0);
      cell_frame(3, bits);
      check("rst_mid_bit", 32'(one), 32'd1);
      #2 reset = 1'b0;
      #1 check("rst_async", 32'({ev_ready, one, zero, senack, done, err}), 32'b100000);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_no_done_err", 32'((n_done - d0) + (n_err - e0)), 32'd0);
      send_event(8'h01, 1'b0);
      cell_frame(8, bits);
      check("01_bits", 32'(bits), 32'h0001);
      check("01_done", 32'(done), 32'd1);
      repeat (2) @(negedge clk);

`ifdef AER_PARITY_EN
      send_event(8'h07, 1'b0);
      cell_frame(9, bits);
      check("par07_bits", 32'(bits), 32'h000F);
      check("par07_done", 32'(done), 32'd1);
      repeat (2) @(negedge clk);
      send_event(8'h03, 1'b0);
      cell_frame(9, bits);
      check("par03_bits", 32'(bits), 32'h0006);
      check("par03_done", 32'(done), 32'd1);
`else
      send_event(8'h07, 1'b0);
      cell_frame(8, bits);
      check("nopar07_bits", 32'(bits), 32'h0007);
      check("nopar07_done", 32'(done), 32'd1);
`endif
      repeat (2) @(negedge clk);
      check("final_idle", 32'({ev_ready, one, zero, senack}), 32'b1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/aer_bit_serializer.md
AER_BIT_SERIALIZER -- requirements
Module: aer_bit_serializer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: event address width in bits, legal range 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023: maximum clk cycles spent waiting in one handshake phase.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset, 1 = run), as in the bit cells.
REQ-005 SHALL have port ev_valid, input, 1: an upstream event is presented.
REQ-006 SHALL have port ev_addr, input, ADDR_W: event address, sampled on acceptance.
REQ-007 SHALL have port ev_ready, output, 1: the serializer can accept an event.
REQ-008 SHALL have port one, output, 1: registered request to the One bit cell.
REQ-009 SHALL have port zero, output, 1: registered request to the Zero bit cell.
REQ-010 SHALL have port dt, input, 1: asynchronous OR of the cells' Dt outputs.
REQ-011 SHALL have port senack, output, 1: registered sender-acknowledge to the cells.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when the last bit completes.
REQ-013 SHALL have port err, output, 1: one-cycle pulse when a handshake times out.

Function
REQ-014 SHALL implement states IDLE, DRIVE and RELEASE.
REQ-015 SHALL hold ev_ready=1 only in IDLE; an event is accepted when ev_valid and ev_ready are both 1 on a clock edge.
REQ-016 SHALL, on acceptance, latch ev_addr into a shift register, load bit count ADDR_W and enter DRIVE.
REQ-017 SHALL send bits MSB first.
REQ-018 SHALL assert one (bit=1) or zero (bit=0) in DRIVE, starting the cycle after acceptance; one and zero SHALL never be 1 together.
REQ-019 SHALL, in DRIVE, on synchronized dt=1: drop one/zero, raise senack and enter RELEASE.
REQ-020 SHALL, in RELEASE, on synchronized dt=0: drop senack, shift, decrement count; then enter DRIVE if bits remain, else pulse done and enter IDLE.
REQ-021 SHALL synchronize dt through exactly 2 flops before use; response latency is 3 edges from a dt transition to the output change.
REQ-022 SHALL reset a phase counter on every state entry; when it reaches TIMEOUT_CYC in DRIVE or RELEASE, the block SHALL pulse err, clear one, zero and senack, and return to IDLE with no done pulse.
REQ-023 SHALL ignore ev_valid outside IDLE; a new event SHALL not be accepted in the same cycle done is pulsed.
REQ-024 SHALL sample the bit count, which is clog2(ADDR_W+1) bits wide, without wrap; the count SHALL never underflow below 0.
REQ-025 SHALL treat a dt that is already 1 on DRIVE entry as an immediate acknowledge; the bench flags this case as a protocol warning only.

Reset
REQ-026 SHALL, while reset=0 (asynchronous), force: state IDLE, ev_ready=1, one=0, zero=0, senack=0, done=0, err=0, shift register 0, counters 0, synchronizer flops 0.
REQ-027 SHALL abandon a mid-frame transfer on reset assertion without emitting done or err.

Configuration
REQ-028 SHALL, with AER_PARITY_EN defined, send one extra bit after the address: the even-parity bit, XOR of ev_addr, using the same handshake; the count loads ADDR_W+1.
REQ-029 SHALL, without AER_PARITY_EN, send exactly ADDR_W bits and contain no parity logic.

Structure
REQ-030 SHALL take from shared package aer_pkg: the state enum aer_ser_state_t (IDLE, DRIVE, RELEASE) and the constant AER_SYNC_STAGES=2.
REQ-031 SHALL instantiate the dt synchronizer as sub-module aer_sync2, clocked by clk with the same reset, reusable by other AER blocks.

Verification
REQ-032 SHALL cover, with ADDR_W=8: ev_addr=0xA5, cell model acking after 4 cycles -> one/zero sequence 1,0,1,0,0,1,0,1; exactly one done; err=0.
REQ-033 SHALL cover: ev_valid held 1 with a second address 0x3C during a frame -> 0x3C accepted only after done, and its frame starts in the cycle after ev_ready returns to 1.
REQ-034 SHALL cover: TIMEOUT_CYC=15, dt never rises -> err pulses, with one or zero first asserted 15 cycles earlier; then IDLE with all request outputs at 0.
REQ-035 SHALL cover: reset asserted to 0 during bit 3 of 0xFF -> all outputs reach their reset values in the same delta; no done or err; the next event 0x01 is sent correctly.
REQ-036 SHALL cover: AER_PARITY_EN defined, ev_addr=0x07 -> 9 bits sent with final bit 1; ev_addr=0x03 -> final bit 0.
REQ-037 SHALL cover: dt stuck 1 in RELEASE -> err after TIMEOUT_CYC cycles with senack cleared.
